// File: rtl/sync_period_checker_if.sv
// sync_period_checker_if: toggle strobe in, measured interval and status out
interface sync_period_checker_if #(
  parameter int N = 4
);
  logic         sync_in;
  logic [N-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         err;
  modport master (output sync_in, input period, period_valid, locked, err);
  modport slave  (input sync_in, output period, period_valid, locked, err);
endinterface

// File: rtl/sync_period_checker.sv
// sync_period_checker: measures toggle intervals, locks on a run of matches, flags mismatches and timeouts
module sync_period_checker #(
  parameter int N        = 4,
  parameter int M        = 10,
  parameter int LOCK_CNT = 3
) (
  input logic                  clk,
  input logic                  rst,
  sync_period_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  localparam logic [N-1:0] MAX = '1;
  localparam logic [N-1:0] M_N = N'(M);
  localparam logic [3:0]   L   = 4'(LOCK_CNT);
  state_t       r_state;
  logic         r_sync_d;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_period;
  logic [3:0]   r_mcnt;
  logic         r_valid;
  logic         r_locked;
  logic         r_err;
  logic         w_edge;
  logic         w_match;
  logic         w_sat;
  logic [3:0]   w_mcnt_inc;
  assign w_edge     = bus.sync_in ^ r_sync_d;
  assign w_match    = r_cnt == M_N;
  assign w_sat      = r_cnt == MAX;
  assign w_mcnt_inc = (r_mcnt == 4'hf) ? r_mcnt : r_mcnt + 4'd1;
  // edge history and saturating interval counter; reset preloads history so no false edge follows reset
  always_ff @(posedge clk) begin
    r_sync_d <= bus.sync_in;
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_edge ? N'(1) : (w_sat ? r_cnt : r_cnt + N'(1));
  end
  // lock FSM with registered period, pulses and lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_mcnt   <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (w_edge) begin
          r_state <= MEASURE;
          r_mcnt  <= '0;
        end
        MEASURE: if (w_edge) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
          if (w_match) begin
            r_mcnt <= w_mcnt_inc;
            if (w_mcnt_inc == L) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end else begin
            r_err  <= 1'b1;
            r_mcnt <= '0;
          end
        end else if (w_sat) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end
        LOCKED: if (w_edge) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
          if (w_match) r_mcnt <= w_mcnt_inc;
          else begin
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_mcnt   <= '0;
            r_state  <= MEASURE;
          end
        end else if (w_sat) begin
          r_err    <= 1'b1;
          r_locked <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.period       = r_period;
  assign bus.period_valid = r_valid;
  assign bus.locked       = r_locked;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_sync_period_checker.sv
// tb_sync_period_checker: table-driven toggle gaps with a timed scoreboard of expected events
module tb_sync_period_checker;
  localparam int K_TGL = 0;
  localparam int K_TO  = 1;
  localparam int K_RST = 2;
  localparam int NV    = 26;
  typedef struct {int kind; int gap; bit ev; logic [3:0] per; bit err; bit lck;} vec_t;
  typedef struct {int due; bit valid; logic [3:0] per; bit err; bit lck;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   last = 0;
  bit   mon_en = 0;
  bit   exp_locked = 0;
  int   exp_period = 0;
  exp_t sb[$];
  vec_t tbl[NV];
  sync_period_checker_if #(.N(4)) b1 ();
  sync_period_checker_if #(.N(4)) b2 ();
  sync_period_checker #(.N(4), .M(10), .LOCK_CNT(3)) u_dut (.clk(clk), .rst(rst), .bus(b1));
  sync_period_checker #(.N(4), .M(1), .LOCK_CNT(1)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string nm, int act, int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
    end
  endfunction
  // scoreboard monitor: every pulse must match the oldest expectation, on its due cycle
  always @(negedge clk) if (mon_en) begin
    if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("missed_event", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (b1.period_valid || b1.err) begin
      if (sb.size() == 0) chk("spurious_event", {b1.period_valid, b1.err}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_cycle", cyc, e.due);
        chk("period_valid", b1.period_valid, e.valid);
        chk("err", b1.err, e.err);
        chk("locked_at_event", b1.locked, e.lck);
        if (e.valid) begin
          chk("period", b1.period, e.per);
          exp_period = e.per;
        end
        exp_locked = e.lck;
      end
    end else begin
      chk("locked_hold", b1.locked, exp_locked);
      chk("period_hold", b1.period, exp_period);
    end
  end
  task automatic chk_zero(string nm);
    chk({nm, "_period"}, b1.period, 0);
    chk({nm, "_valid"}, b1.period_valid, 0);
    chk({nm, "_locked"}, b1.locked, 0);
    chk({nm, "_err"}, b1.err, 0);
  endtask
  initial begin
    tbl[0]  = '{K_TGL, 3, 0, 4'd0, 0, 0};
    tbl[1]  = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[2]  = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[3]  = '{K_TGL, 10, 1, 4'd10, 0, 1};
    tbl[4]  = '{K_TGL, 10, 1, 4'd10, 0, 1};
    tbl[5]  = '{K_TGL, 9, 1, 4'd9, 1, 0};
    tbl[6]  = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[7]  = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[8]  = '{K_TGL, 10, 1, 4'd10, 0, 1};
    tbl[9]  = '{K_TO, 0, 1, 4'd0, 1, 0};
    tbl[10] = '{K_TGL, 20, 0, 4'd0, 0, 0};
    tbl[11] = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[12] = '{K_TGL, 1, 1, 4'd1, 1, 0};
    tbl[13] = '{K_TGL, 1, 1, 4'd1, 1, 0};
    tbl[14] = '{K_TGL, 1, 1, 4'd1, 1, 0};
    tbl[15] = '{K_TGL, 1, 1, 4'd1, 1, 0};
    tbl[16] = '{K_TGL, 15, 1, 4'd15, 1, 0};
    tbl[17] = '{K_TO, 0, 1, 4'd0, 1, 0};
    tbl[18] = '{K_TGL, 4, 0, 4'd0, 0, 0};
    tbl[19] = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[20] = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[21] = '{K_TGL, 10, 1, 4'd10, 0, 1};
    tbl[22] = '{K_RST, 5, 0, 4'd0, 0, 0};
    tbl[23] = '{K_TGL, 20, 0, 4'd0, 0, 0};
    tbl[24] = '{K_TGL, 10, 1, 4'd10, 0, 0};
    tbl[25] = '{K_TO, 0, 1, 4'd0, 1, 0};
    b1.sync_in = 0;
    b2.sync_in = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    mon_en = 1;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].kind == K_TGL) begin
        repeat (tbl[i].gap) @(negedge clk);
        b1.sync_in = ~b1.sync_in;
        last = cyc;
        if (tbl[i].ev) sb.push_back('{cyc + 1, 1'b1, tbl[i].per, tbl[i].err, tbl[i].lck});
      end else if (tbl[i].kind == K_TO) begin
        sb.push_back('{last + 16, 1'b0, 4'd0, 1'b1, 1'b0});
        repeat (18) @(negedge clk);
      end else begin
        repeat (tbl[i].gap) @(negedge clk);
        mon_en = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_zero("midrun_reset");
        exp_locked = 0;
        exp_period = 0;
        mon_en = 1;
      end
    end
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    @(negedge clk);
    b2.sync_in = ~b2.sync_in;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("m1_valid", b2.period_valid, i > 0);
      chk("m1_locked", b2.locked, i > 0);
      chk("m1_err", b2.err, 0);
      if (i > 0) chk("m1_period", b2.period, 1);
      b2.sync_in = ~b2.sync_in;
    end
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sync_period_checker.md
# sync_period_checker

Receive-side monitor for the divided toggle strobe produced by the team's counter/divider blocks. Samples a single-bit toggle signal in the same clock domain, measures the clock-cycle interval between successive toggles, and compares it against an expected divide ratio. It reports each measured interval, asserts `locked` after a run of correct intervals, and flags wrong intervals and missing toggles on `err`.

## Interface
- `N`, default 4: interval counter width; largest measurable interval is 2^N-1.
- `M`, default 4'd10: expected interval in clk cycles between toggles; legal range 1..2^N-2.
- `LOCK_CNT`, default 3: number of consecutive matching intervals required to lock; legal range 1..15.
- `clk`  input  1  sole clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `sync_in`  input  1  toggle strobe, synchronous to `clk`; every level change is one event.
- `period`  output  N  last measured interval in clk cycles.
- `period_valid`  output  1  one-cycle pulse when `period` updates.
- `locked`  output  1  high while the interval stream matches `M`.
- `err`  output  1  one-cycle pulse on a mismatched interval or a timeout.

## Operation
- Edge detect: register `sync_d` holds the previous `sync_in`. `edge = sync_in ^ sync_d`. During reset, `sync_d` loads `sync_in`, so there is no spurious edge after reset.
- Interval counter `cnt`, N bits:
  - On `edge`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 2^N-1.
  - The value of `cnt` in the cycle of the next edge equals the number of cycles since the previous edge.
- Match counter `mcnt`: 4 bits, saturating.
- State machine, 3 states:
  - IDLE: waiting for the first edge. `locked` = 0. No measurement. On `edge` go to MEASURE and set `mcnt` = 0. The partial interval before the first edge is discarded.
  - MEASURE: on `edge`, set `period <= cnt` and pulse `period_valid`.
    - If `cnt == M`: increment `mcnt`. When the incremented value reaches LOCK_CNT, go to LOCKED.
    - If `cnt != M`: pulse `err`, set `mcnt` = 0, stay in MEASURE.
  - LOCKED: `locked` = 1. On `edge`, set `period <= cnt` and pulse `period_valid`.
    - If `cnt != M`: pulse `err`, drop `locked`, set `mcnt` = 0, go to MEASURE.
- Timeout: in MEASURE or LOCKED, when `cnt` = 2^N-1 and there is no edge this cycle, pulse `err`, drop `locked`, and go to IDLE. `period` is not updated.
- Simultaneous events: an edge in the saturation cycle counts as an edge, not a timeout. The measured `period` is 2^N-1, which is a mismatch because `M` is at most 2^N-2.
- Width rule: the comparison `cnt == M` uses N bits. `M` is truncated to N bits.

## Timing
- Reset values: `period` = 0, `period_valid` = 0, `locked` = 0, `err` = 0, `cnt` = 0, `mcnt` = 0, state = IDLE.
- Reset asserted mid-operation returns all of the above to their reset values at the next rising edge.
- Latency: a toggle on `sync_in` sampled at rising edge t is detected in cycle t. `period`, `period_valid`, `err` and `locked` reflect it after rising edge t+1 (1-cycle registered latency).
- `period_valid` and `err` are each high for exactly one cycle per event. They may be high together in the same cycle on a mismatch.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_CNT-th consecutive matching interval.
- Timeout `err` occurs one cycle after `cnt` reaches 2^N-1. For N=4 that is 15 cycles after the last edge with no toggle.
- `period` holds its value between updates.

## Test plan
All scenarios use defaults N=4, M=10, LOCK_CNT=3.
- Reset, then toggle `sync_in` every 10 cycles -> first edge gives no `period_valid`. Each later edge gives `period`=10 with `period_valid`, and `err` stays 0. `locked` rises with the 3rd valid period (4th edge).
- While locked, make one interval 9 cycles -> `period`=9, `period_valid` and `err` in the same cycle, `locked` falls. Three further 10-cycle intervals relock.
- Stop toggling after lock -> `err` pulses 15 cycles after the last edge, `locked` = 0, state is IDLE. The next two edges give one `period_valid` only (the first edge is discarded).
- Toggle `sync_in` every cycle after the first edge -> `period`=1, with `err` on every valid period and `locked` never set. Then a toggle exactly 15 cycles after the previous one -> `period`=15, `err` pulses once (mismatch), no separate timeout.
- Assert `rst` for 1 cycle midway through a 10-cycle interval while locked -> all outputs are 0 next cycle. Holding `sync_in` constant across reset produces no edge. Measurement restarts from IDLE.
- Sweep M=1, LOCK_CNT=1 with `sync_in` toggling every cycle -> `locked` rises on the 2nd edge's `period_valid`, and `err` stays 0.
